// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
// Imported by the update datapath and by the scheduler top.
package lif_neuron_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sched_state_t;

    localparam logic CFG_THR  = 1'b0;
    localparam logic CFG_LEAK = 1'b1;

    localparam int THR_RST  = 32;
    localparam int LEAK_RST = 1;
    localparam int LEAK_W   = 2;

endpackage

// File: rtl/lif_neuron_scheduler_if.sv
// Current-beat stream into the scheduler and the spike event stream out of it.
interface lif_neuron_scheduler_if #(
    parameter int IDX_W   = 3,
    parameter int STATE_W = 6
) ();
    logic               cur_valid;
    logic               cur_ready;
    logic [IDX_W-1:0]   cur_idx;
    logic [STATE_W-1:0] cur_data;
    logic               spike_valid;
    logic [IDX_W-1:0]   spike_idx;

    modport master (
        output cur_valid, cur_idx, cur_data,
        input  cur_ready, spike_valid, spike_idx
    );

    modport slave (
        input  cur_valid, cur_idx, cur_data,
        output cur_ready, spike_valid, spike_idx
    );
endinterface

// File: rtl/lif_neuron_scheduler_lif_update.sv
// Combinational leaky-integrate-and-fire step for one neuron: leak by shift,
// add buffered current with saturation, compare against threshold.
module lif_update
    import lif_neuron_scheduler_pkg::*;
#(
    parameter int STATE_W = 6
) (
    input  logic [STATE_W-1:0] state,
    input  logic [STATE_W-1:0] cur,
    input  logic [LEAK_W-1:0]  leak_sh,
    input  logic [STATE_W-1:0] thr,
    output logic [STATE_W-1:0] next_state,
    output logic               fire
);
    logic [STATE_W-1:0] leaked;
    logic [STATE_W:0]   sum;
    logic [STATE_W-1:0] v;

    always_comb begin
        leaked     = state >> leak_sh;
        sum        = {1'b0, cur} + {1'b0, leaked};
        v          = sum[STATE_W] ? '1 : sum[STATE_W-1:0];
        fire       = (v >= thr);
        next_state = fire ? '0 : v;
    end
endmodule

// File: rtl/lif_neuron_scheduler.sv
// N virtual LIF neurons sharing one update datapath; a tick sweeps all neurons
// in index order, one per cycle, emitting a registered spike per firing neuron.
module lif_neuron_scheduler
    import lif_neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int STATE_W   = 6,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic                 cfg_addr,
    input  logic [STATE_W-1:0]   cfg_data,
    input  logic                 tick,
    output logic                 busy,
    output logic                 overrun,
    lif_neuron_scheduler_if.slave bus
);
    sched_state_t       state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;

    logic [STATE_W-1:0] neuron_state_reg [N_NEURONS];
    logic [STATE_W-1:0] cur_buf_reg      [N_NEURONS];

    logic [STATE_W-1:0] thr_reg, thr_shadow_reg;
    logic [LEAK_W-1:0]  leak_reg, leak_shadow_reg;
    logic               spike_valid_reg;
    logic [IDX_W-1:0]   spike_idx_reg;
    logic               overrun_reg;

    logic               cfg_thr_hit, cfg_leak_hit;
    logic [STATE_W-1:0] thr_eff;
    logic [LEAK_W-1:0]  leak_eff;
    logic               tick_start;
    logic               beat_fire;
    logic [STATE_W:0]   beat_sum_wide;
    logic [STATE_W-1:0] beat_sum;
    logic [STATE_W-1:0] upd_next;
    logic               upd_fire;
    logic [N_NEURONS-1:0] beat_hit;
    logic [N_NEURONS-1:0] upd_hit;

    assign busy            = (state_reg == SWEEP);
    assign bus.cur_ready   = (state_reg == IDLE);
    assign bus.spike_valid = spike_valid_reg;
    assign bus.spike_idx   = spike_idx_reg;
    assign overrun         = overrun_reg;

    // A config write coinciding with the starting tick must land in the shadow too.
    assign cfg_thr_hit  = cfg_we && (cfg_addr == CFG_THR);
    assign cfg_leak_hit = cfg_we && (cfg_addr == CFG_LEAK);
    assign thr_eff      = cfg_thr_hit  ? cfg_data : thr_reg;
    assign leak_eff     = cfg_leak_hit ? cfg_data[LEAK_W-1:0] : leak_reg;
    assign tick_start   = (state_reg == IDLE) && tick;

    assign beat_fire     = bus.cur_valid && bus.cur_ready;
    assign beat_sum_wide = {1'b0, cur_buf_reg[bus.cur_idx]} + {1'b0, bus.cur_data};
    assign beat_sum      = beat_sum_wide[STATE_W] ? '1 : beat_sum_wide[STATE_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_dec
            assign beat_hit[gi] = beat_fire && (bus.cur_idx == IDX_W'(gi));
            assign upd_hit[gi]  = busy && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    lif_update #(
        .STATE_W (STATE_W)
    ) u_lif_update (
        .state      (neuron_state_reg[idx_reg]),
        .cur        (cur_buf_reg[idx_reg]),
        .leak_sh    (leak_shadow_reg),
        .thr        (thr_shadow_reg),
        .next_state (upd_next),
        .fire       (upd_fire)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                if (idx_reg == IDX_W'(N_NEURONS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            thr_reg         <= STATE_W'(THR_RST);
            leak_reg        <= LEAK_W'(LEAK_RST);
            thr_shadow_reg  <= STATE_W'(THR_RST);
            leak_shadow_reg <= LEAK_W'(LEAK_RST);
            spike_valid_reg <= 1'b0;
            spike_idx_reg   <= '0;
            overrun_reg     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                neuron_state_reg[i] <= '0;
                cur_buf_reg[i]      <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (cfg_thr_hit)  thr_reg  <= cfg_data;
            if (cfg_leak_hit) leak_reg <= cfg_data[LEAK_W-1:0];
            if (tick_start) begin
                thr_shadow_reg  <= thr_eff;
                leak_shadow_reg <= leak_eff;
            end
            if (tick && busy) overrun_reg <= 1'b1;
            spike_valid_reg <= busy && upd_fire;
            if (busy && upd_fire) spike_idx_reg <= idx_reg;
            // Beats are only accepted in IDLE, so they never collide with a sweep clear.
            for (int i = 0; i < N_NEURONS; i++) begin
                if (upd_hit[i]) begin
                    neuron_state_reg[i] <= upd_next;
                    cur_buf_reg[i]      <= '0;
                end else if (beat_hit[i]) begin
                    cur_buf_reg[i] <= beat_sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler: hand-computed spike patterns,
// saturation, overrun, shadowed config and mid-sweep reset.
module tb_lif_neuron_scheduler;
    localparam int N  = 8;
    localparam int SW = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic          cfg_addr = 1'b0;
    logic [SW-1:0] cfg_data = '0;
    logic          tick = 1'b0;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    lif_neuron_scheduler_if #(.IDX_W(IW), .STATE_W(SW)) bus ();

    lif_neuron_scheduler #(
        .N_NEURONS (N),
        .STATE_W   (SW),
        .IDX_W     (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .tick     (tick),
        .busy     (busy),
        .overrun  (overrun),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int idx, input int data);
        bus.cur_valid = 1'b1;
        bus.cur_idx   = IW'(idx);
        bus.cur_data  = SW'(data);
        step();
        bus.cur_valid = 1'b0;
        $display("beat idx=%0d data=%0d", idx, data);
    endtask

    task automatic cfg_write(input bit addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = SW'(data);
        step();
        cfg_we = 1'b0;
        $display("cfg addr=%0d data=%0d", addr, data);
    endtask

    // Tick in the current cycle t, then check cycles t+1..t+N+1.
    task automatic run_sweep(input string name, input logic [N-1:0] mask,
                             input bit beat_en, input int bidx, input int bdata);
        tick = 1'b1;
        if (beat_en) begin
            bus.cur_valid = 1'b1;
            bus.cur_idx   = IW'(bidx);
            bus.cur_data  = SW'(bdata);
        end
        step();
        tick          = 1'b0;
        cfg_we        = 1'b0;
        bus.cur_valid = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            check($sformatf("%s busy c%0d", name, c), int'(busy), (c <= N) ? 1 : 0);
            check($sformatf("%s ready c%0d", name, c), int'(bus.cur_ready), (c <= N) ? 0 : 1);
            if (c >= 2) begin
                check($sformatf("%s sv c%0d", name, c), int'(bus.spike_valid), int'(mask[c-2]));
                if (mask[c-2])
                    check($sformatf("%s sidx c%0d", name, c), int'(bus.spike_idx), c - 2);
            end else begin
                check($sformatf("%s sv c%0d", name, c), int'(bus.spike_valid), 0);
            end
            if (c <= N) step();
        end
        $display("sweep %s mask=%b", name, mask);
    endtask

    initial begin
        bus.cur_valid = 1'b0;
        bus.cur_idx   = '0;
        bus.cur_data  = '0;
        repeat (3) step();
        reset = 1'b0;

        check("rst busy", int'(busy), 0);
        check("rst spike_valid", int'(bus.spike_valid), 0);
        check("rst spike_idx", int'(bus.spike_idx), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst cur_ready", int'(bus.cur_ready), 1);
        check("rst thr", int'(dut.thr_reg), 32);
        check("rst leak", int'(dut.leak_reg), 1);

        run_sweep("empty", 8'h00, 1'b0, 0, 0);
        for (int k = 0; k < N; k++)
            check($sformatf("empty state%0d", k), int'(dut.neuron_state_reg[k]), 0);

        // Beat in the tick cycle is integrated by the same sweep.
        run_sweep("n3", 8'h08, 1'b1, 3, 40);
        check("n3 state", int'(dut.neuron_state_reg[3]), 0);

        run_sweep("n5a", 8'h00, 1'b1, 5, 20);
        check("n5a state", int'(dut.neuron_state_reg[5]), 20);
        run_sweep("n5b", 8'h00, 1'b1, 5, 20);
        check("n5b state", int'(dut.neuron_state_reg[5]), 30);
        run_sweep("n5c", 8'h20, 1'b1, 5, 20);
        check("n5c state", int'(dut.neuron_state_reg[5]), 0);

        send_beat(2, 50);
        send_beat(2, 50);
        check("sat cur_buf2", int'(dut.cur_buf_reg[2]), 63);
        run_sweep("sat", 8'h04, 1'b0, 0, 0);
        check("sat state2", int'(dut.neuron_state_reg[2]), 0);

        // Overrun plus shadowed threshold: this sweep keeps 32, the next uses 10.
        send_beat(7, 20);
        tick = 1'b1;
        step();                      // t+1
        tick = 1'b0;
        step();                      // t+2
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_data = 6'd10;
        step();                      // t+3
        cfg_we = 1'b0;
        tick = 1'b1;
        check("ovr busy t+3", int'(busy), 1);
        step();                      // t+4
        tick = 1'b0;
        check("ovr overrun", int'(overrun), 1);
        check("ovr live thr", int'(dut.thr_reg), 10);
        for (int c = 4; c <= 9; c++) begin
            check($sformatf("ovr busy t+%0d", c), int'(busy), (c <= 8) ? 1 : 0);
            check($sformatf("ovr sv t+%0d", c), int'(bus.spike_valid), 0);
            if (c < 9) step();
        end
        check("ovr state7", int'(dut.neuron_state_reg[7]), 20);
        $display("sweep overrun with cfg thr=10 mid-sweep");
        run_sweep("thr10", 8'h80, 1'b0, 0, 0);
        check("ovr sticky", int'(overrun), 1);

        // Reset in cycle t+4 of a sweep.
        send_beat(6, 40);
        tick = 1'b1;
        step();                      // t+1
        tick = 1'b0;
        step();                      // t+2
        step();                      // t+3
        step();                      // t+4
        reset = 1'b1;
        step();                      // t+5
        reset = 1'b0;
        check("mid rst busy", int'(busy), 0);
        check("mid rst sv", int'(bus.spike_valid), 0);
        check("mid rst ready", int'(bus.cur_ready), 1);
        check("mid rst overrun", int'(overrun), 0);
        check("mid rst cur_buf6", int'(dut.cur_buf_reg[6]), 0);
        check("mid rst thr", int'(dut.thr_reg), 32);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("mid rst idle sv %0d", c), int'(bus.spike_valid), 0);
        end
        $display("reset mid-sweep");

        // Threshold 0 written in the tick cycle: everyone fires.
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_data = 6'd0;
        run_sweep("thr0", 8'hFF, 1'b0, 0, 0);

        // Leak shift 0: no decay between sweeps.
        cfg_write(1'b0, 32);
        cfg_write(1'b1, 0);
        run_sweep("leak0a", 8'h00, 1'b1, 1, 20);
        check("leak0a state1", int'(dut.neuron_state_reg[1]), 20);
        run_sweep("leak0b", 8'h02, 1'b1, 1, 20);
        check("leak0b state1", int'(dut.neuron_state_reg[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
